mem_hs_bd: RTL and testbench

MEM_HS_BD -- requirements
Module: mem_hs_bd

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_array_be.sv | 29 ++
 rtl/mem_hs_bd.sv | 138 +++++++++++++
 tb/tb_mem_hs_bd.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the handshake memory with back-door access.
package mem_pkg;

   typedef enum logic [1:0] {
      StInit = 2'd0,
      StIdle = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam int unsigned DefWidth     = 16;
   localparam int unsigned DefDepth     = 64;
   localparam int unsigned DefAddrWidth = 6;

endpackage

// File: rtl/mem_array_be.sv
// Single-port storage array: byte-enabled synchronous write, combinational read.
module mem_array_be #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned IDX_WIDTH = 6
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [IDX_WIDTH-1:0] idx_i,
   input  logic [WIDTH-1:0]     wdata_i,
   input  logic [WIDTH/8-1:0]   be_i,
   output logic [WIDTH-1:0]     rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < WIDTH / 8; b++) begin
            if (be_i[b]) begin
               mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_hs_bd.sv
// Valid/ready front-door memory with priority back-door port and clear-on-reset sequencing.
module mem_hs_bd
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned DEPTH      = DefDepth,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_wr_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [WIDTH-1:0]      req_wdata_i,
   input  logic [WIDTH/8-1:0]    req_be_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [WIDTH-1:0]      resp_rdata_o,
   output logic                  resp_err_o,
   input  logic                  bd_en_i,
   input  logic                  bd_wr_i,
   input  logic [ADDR_WIDTH-1:0] bd_addr_i,
   input  logic [WIDTH-1:0]      bd_wdata_i,
   output logic [WIDTH-1:0]      bd_rdata_o,
   output logic                  init_done_o
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BeW  = WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DepthA  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IdxW-1:0]     LastIdx = IdxW'(DEPTH - 1);

   state_e            state_q;
   logic [IdxW-1:0]   init_cnt_q;
   logic              init_done_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [WIDTH-1:0]  resp_rdata_q;
   logic [WIDTH-1:0]  bd_rdata_q;

   logic              fd_in_range;
   logic              bd_in_range;
   logic              accept;
   logic              mem_we;
   logic [IdxW-1:0]   mem_idx;
   logic [WIDTH-1:0]  mem_wdata;
   logic [WIDTH-1:0]  mem_rdata;
   logic [BeW-1:0]    mem_be;

   assign fd_in_range = {1'b0, req_addr_i} < DepthA;
   assign bd_in_range = {1'b0, bd_addr_i} < DepthA;
   assign req_ready_o = ((state_q == StIdle) || ((state_q == StResp) && resp_ready_i))
                        && !bd_en_i;
   assign accept      = req_valid_i && req_ready_o;

   // One physical port: clear sequence, then back-door, then front-door.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (state_q == StInit) begin
         mem_we  = 1'b1;
         mem_idx = init_cnt_q;
         mem_be  = '1;
      end else if (bd_en_i) begin
         mem_we    = bd_wr_i && bd_in_range;
         mem_idx   = bd_addr_i[IdxW-1:0];
         mem_wdata = bd_wdata_i;
         mem_be    = '1;
      end else begin
         mem_we    = accept && req_wr_i && fd_in_range;
         mem_idx   = req_addr_i[IdxW-1:0];
         mem_wdata = req_wdata_i;
         mem_be    = req_be_i;
      end
   end

   mem_array_be #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .IDX_WIDTH(IdxW)
   ) u_array (
      .clk_i  (clk_i),
      .we_i   (mem_we),
      .idx_i  (mem_idx),
      .wdata_i(mem_wdata),
      .be_i   (mem_be),
      .rdata_o(mem_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StInit;
         init_cnt_q   <= '0;
         init_done_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         bd_rdata_q   <= '0;
      end else begin
         unique case (state_q)
            StInit: begin
               init_cnt_q <= init_cnt_q + 1'b1;
               if (init_cnt_q == LastIdx) begin
                  state_q     <= StIdle;
                  init_done_q <= 1'b1;
               end
            end
            StIdle, StResp: begin
               if (accept) begin
                  state_q      <= StResp;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= !fd_in_range;
                  resp_rdata_q <= (!req_wr_i && fd_in_range) ? mem_rdata : '0;
               end else if ((state_q == StResp) && resp_ready_i) begin
                  state_q      <= StIdle;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= '0;
               end
               if (bd_en_i && !bd_wr_i) begin
                  bd_rdata_q <= bd_in_range ? mem_rdata : '0;
               end
            end
            default: state_q <= StInit;
         endcase
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;
   assign bd_rdata_o   = bd_rdata_q;
   assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_mem_hs_bd.sv
// Scoreboard bench for mem_hs_bd: front-door responses checked against a reference memory model.
module tb_mem_hs_bd;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 64;
   localparam int unsigned AW = 7;

   logic          clk;
   logic          rst_ni;
   logic          req_valid;
   logic          req_ready_o;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [W-1:0]  req_wdata;
   logic [1:0]    req_be;
   logic          resp_valid_o;
   logic          resp_ready;
   logic [W-1:0]  resp_rdata_o;
   logic          resp_err_o;
   logic          bd_en;
   logic          bd_wr;
   logic [AW-1:0] bd_addr;
   logic [W-1:0]  bd_wdata;
   logic [W-1:0]  bd_rdata_o;
   logic          init_done_o;

   typedef struct packed {
      logic [W-1:0] rdata;
      logic         err;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] model [D];
   int           n_tests = 0;
   int           n_fail  = 0;

   mem_hs_bd #(
      .WIDTH     (W),
      .DEPTH     (D),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_wr_i    (req_wr),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_be_i    (req_be),
      .resp_valid_o(resp_valid_o),
      .resp_ready_i(resp_ready),
      .resp_rdata_o(resp_rdata_o),
      .resp_err_o  (resp_err_o),
      .bd_en_i     (bd_en),
      .bd_wr_i     (bd_wr),
      .bd_addr_i   (bd_addr),
      .bd_wdata_i  (bd_wdata),
      .bd_rdata_o  (bd_rdata_o),
      .init_done_o (init_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A response leaves on the edge following a low-phase sample of valid && ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst_ni && resp_valid_o && resp_ready) begin
         check_val("sb_has_entry", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("resp_rdata", 32'(resp_rdata_o), 32'(e.rdata));
            check_val("resp_err", 32'(resp_err_o), 32'(e.err));
         end
      end
   end

   task automatic fd_req(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                         input logic [1:0] be, output int waits);
      exp_t e;
      logic ok;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      waits     = 0;
      ok        = 1'b0;
      while (!ok && waits < 50) begin
         @(negedge clk);
         if (req_ready_o) ok = 1'b1;
         else waits++;
      end
      check_val("accept", 32'(ok), 1);
      if (ok) begin
         if (addr >= AW'(D)) begin
            e.err   = 1'b1;
            e.rdata = '0;
         end else if (wr) begin
            e.err   = 1'b0;
            e.rdata = '0;
            for (int b = 0; b < 2; b++) begin
               if (be[b]) model[addr[5:0]][b*8 +: 8] = wd[b*8 +: 8];
            end
         end else begin
            e.err   = 1'b0;
            e.rdata = model[addr[5:0]];
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic bd_write(input logic [AW-1:0] addr, input logic [W-1:0] data);
      bd_en    = 1'b1;
      bd_wr    = 1'b1;
      bd_addr  = addr;
      bd_wdata = data;
      tick();
      bd_en = 1'b0;
      bd_wr = 1'b0;
      if (addr < AW'(D)) model[addr[5:0]] = data;
   endtask

   task automatic bd_read(input string tag, input logic [AW-1:0] addr);
      logic [W-1:0] exp;
      bd_en   = 1'b1;
      bd_wr   = 1'b0;
      bd_addr = addr;
      tick();
      bd_en = 1'b0;
      exp   = (addr < AW'(D)) ? model[addr[5:0]] : '0;
      check_val(tag, 32'(bd_rdata_o), 32'(exp));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check_val("drain", 32'(sb.size()), 0);
   endtask

   // Releases reset and walks the clear sequence; noisy mode pokes both ports during it.
   task automatic run_init(input bit noisy);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      if (noisy) begin
         req_valid = 1'b1;
         req_wr    = 1'b1;
         req_addr  = 7'd3;
         req_wdata = 16'hDEAD;
         req_be    = 2'b11;
      end
      for (int i = 1; i <= 64; i++) begin
         if (noisy && i == 20) begin
            check_val("init_ready_low", 32'(req_ready_o), 0);
            req_valid = 1'b0;
         end
         if (noisy && i == 30) begin
            bd_en    = 1'b1;
            bd_wr    = 1'b1;
            bd_addr  = 7'd31;
            bd_wdata = 16'hFFFF;
         end
         if (i == 60) begin
            bd_en = 1'b0;
            bd_wr = 1'b0;
         end
         if (i == 64) begin
            check_val("init_done_early", 32'(init_done_o), 0);
            check_val("init_bd_rdata", 32'(bd_rdata_o), 0);
         end
         tick();
      end
      check_val("init_done", 32'(init_done_o), 1);
      for (int i = 0; i < int'(D); i++) model[i] = '0;
   endtask

   initial begin
      int w;
      rst_ni     = 1'b0;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_be     = '0;
      resp_ready = 1'b1;
      bd_en      = 1'b0;
      bd_wr      = 1'b0;
      bd_addr    = '0;
      bd_wdata   = '0;
      for (int i = 0; i < int'(D); i++) model[i] = '0;

      #12;
      check_val("rst_ready", 32'(req_ready_o), 0);
      check_val("rst_valid", 32'(resp_valid_o), 0);
      check_val("rst_bd_rdata", 32'(bd_rdata_o), 0);
      check_val("rst_init_done", 32'(init_done_o), 0);

      run_init(1'b1);
      bd_read("bd_clear_0", 7'd0);
      bd_read("bd_clear_31", 7'd31);
      bd_read("bd_clear_63", 7'd63);
      bd_read("bd_clear_3", 7'd3);

      // Byte-enable writes and read-back, back-to-back.
      fd_req(1'b1, 7'd5, 16'hABCD, 2'b11, w);
      fd_req(1'b0, 7'd5, 16'h0000, 2'b00, w);
      fd_req(1'b1, 7'd5, 16'h1200, 2'b10, w);
      fd_req(1'b0, 7'd5, 16'h0000, 2'b00, w);
      fd_req(1'b1, 7'd5, 16'hFFFF, 2'b00, w);
      fd_req(1'b0, 7'd5, 16'h0000, 2'b00, w);
      fd_req(1'b1, 7'd6, 16'h3456, 2'b01, w);
      fd_req(1'b0, 7'd6, 16'h0000, 2'b00, w);
      wait_drain();

      // Stalled response stays put, even across a back-door write to the same word.
      bd_write(7'd7, 16'h7777);
      resp_ready = 1'b0;
      fd_req(1'b0, 7'd7, 16'h0000, 2'b00, w);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 7'd8;
      for (int k = 0; k < 3; k++) begin
         check_val("stall_valid", 32'(resp_valid_o), 1);
         check_val("stall_rdata", 32'(resp_rdata_o), 32'h7777);
         check_val("stall_ready", 32'(req_ready_o), 0);
         if (k == 1) bd_write(7'd7, 16'h1111);
         else tick();
      end
      resp_ready = 1'b1;
      fd_req(1'b0, 7'd8, 16'h0000, 2'b00, w);
      check_val("accept_after_stall", 32'(w), 0);
      fd_req(1'b0, 7'd7, 16'h0000, 2'b00, w);
      wait_drain();

      // Back-door blocks the front door in the same cycle.
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 7'd9;
      bd_en     = 1'b1;
      bd_wr     = 1'b1;
      bd_addr   = 7'd9;
      bd_wdata  = 16'h5555;
      #1;
      check_val("bd_blocks_ready", 32'(req_ready_o), 0);
      tick();
      bd_en    = 1'b0;
      bd_wr    = 1'b0;
      model[9] = 16'h5555;
      fd_req(1'b0, 7'd9, 16'h0000, 2'b00, w);
      bd_read("bd_read_9", 7'd9);
      tick();
      tick();
      check_val("bd_rdata_hold", 32'(bd_rdata_o), 32'h5555);
      wait_drain();

      // Out-of-range addresses on both ports.
      fd_req(1'b0, 7'd100, 16'h0000, 2'b00, w);
      fd_req(1'b1, 7'd100, 16'hBEEF, 2'b11, w);
      fd_req(1'b0, 7'd36, 16'h0000, 2'b00, w);
      fd_req(1'b0, 7'd63, 16'h0000, 2'b00, w);
      bd_write(7'd100, 16'hCAFE);
      bd_read("bd_oor_100", 7'd100);
      bd_read("bd_alias_36", 7'd36);
      fd_req(1'b0, 7'd5, 16'h0000, 2'b00, w);
      wait_drain();

      // Reset during a pending response drops it and re-clears memory.
      resp_ready = 1'b0;
      fd_req(1'b0, 7'd5, 16'h0000, 2'b00, w);
      #3;
      rst_ni = 1'b0;
      sb.delete();
      #1;
      check_val("mid_rst_valid", 32'(resp_valid_o), 0);
      check_val("mid_rst_ready", 32'(req_ready_o), 0);
      check_val("mid_rst_init_done", 32'(init_done_o), 0);
      check_val("mid_rst_bd_rdata", 32'(bd_rdata_o), 0);
      resp_ready = 1'b1;
      run_init(1'b0);
      fd_req(1'b0, 7'd5, 16'h0000, 2'b00, w);
      fd_req(1'b0, 7'd9, 16'h0000, 2'b00, w);
      wait_drain();
      tick();
      check_val("idle_valid_low", 32'(resp_valid_o), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
